// File: rtl/poly_eval_pkg.sv
// rtl/poly_eval_pkg.sv - shared state encoding and operand indices for the poly-eval driver
package poly_eval_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_HI  = 3'd1,
    S_LOAD_LO  = 3'd2,
    S_WAIT_RES = 3'd3,
    S_REL      = 3'd4,
    S_REL_LO   = 3'd5,
    S_RESP     = 3'd6
  } state_t;

  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;
  localparam logic [1:0] OP_X = 2'd3;

endpackage

// File: rtl/go_pulse_gen.sv
// rtl/go_pulse_gen.sv - loadable down-counter timing the Go high/low phases
module go_pulse_gen #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Loaded on the state-entry edge with N, so done marks the Nth cycle in the phase.
  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/poly_eval_driver.sv
// rtl/poly_eval_driver.sv - serializes {a,b,c,x} requests into Go-handshaked loads and returns the evaluator result
module poly_eval_driver
  import poly_eval_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int GO_HIGH_CYCLES = 2,
  parameter int GO_LOW_CYCLES  = 2,
  parameter int TIMEOUT        = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_c,
  input  logic [WIDTH-1:0] req_x,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_error,
  output logic             Go,
  output logic [WIDTH-1:0] DataIn,
  input  logic [WIDTH-1:0] DataResult,
  input  logic             ResultValid
);

  localparam int PH_MAX = (GO_HIGH_CYCLES > GO_LOW_CYCLES) ? GO_HIGH_CYCLES : GO_LOW_CYCLES;
  localparam int CNT_W  = $clog2(PH_MAX + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [1:0]       op_idx;
  logic [WIDTH-1:0] op_a, op_b, op_c, op_x;
  logic [WIDTH-1:0] next_op;
  logic [TMO_W-1:0] tmo_cnt;
  logic             ph_load;
  logic [CNT_W-1:0] ph_val;
  logic             ph_done;

  go_pulse_gen #(.CNT_W(CNT_W)) u_go_pulse (
    .clk      (Clock),
    .reset    (Reset),
    .load     (ph_load),
    .load_val (ph_val),
    .done     (ph_done)
  );

  // Phase counter is reloaded on every edge that enters a timed phase.
  always_comb begin
    ph_load = 1'b0;
    ph_val  = '0;
    case (state)
      S_IDLE:     if (req_valid) begin ph_load = 1'b1; ph_val = CNT_W'(GO_HIGH_CYCLES); end
      S_LOAD_HI:  if (ph_done)   begin ph_load = 1'b1; ph_val = CNT_W'(GO_LOW_CYCLES);  end
      S_LOAD_LO:  if (ph_done && op_idx != OP_X) begin ph_load = 1'b1; ph_val = CNT_W'(GO_HIGH_CYCLES); end
      S_WAIT_RES: if (ResultValid) begin ph_load = 1'b1; ph_val = CNT_W'(1); end
      S_REL:      if (ph_done)   begin ph_load = 1'b1; ph_val = CNT_W'(1); end
      default: ;
    endcase
  end

  always_comb begin
    next_op = op_x;
    case (op_idx + 2'd1)
      OP_A:    next_op = op_a;
      OP_B:    next_op = op_b;
      OP_C:    next_op = op_c;
      default: next_op = op_x;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_data  <= '0;
      Go        <= 1'b0;
      DataIn    <= '0;
      op_idx    <= OP_A;
      op_a      <= '0;
      op_b      <= '0;
      op_c      <= '0;
      op_x      <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_a      <= req_a;
            op_b      <= req_b;
            op_c      <= req_c;
            op_x      <= req_x;
            DataIn    <= req_a;
            op_idx    <= OP_A;
            Go        <= 1'b1;
            req_ready <= 1'b0;
            state     <= S_LOAD_HI;
          end
        end
        S_LOAD_HI: begin
          if (ph_done) begin
            Go    <= 1'b0;
            state <= S_LOAD_LO;
          end
        end
        S_LOAD_LO: begin
          if (ph_done) begin
            if (op_idx != OP_X) begin
              op_idx <= op_idx + 2'd1;
              DataIn <= next_op;
              Go     <= 1'b1;
              state  <= S_LOAD_HI;
            end else begin
              tmo_cnt <= '0;
              state   <= S_WAIT_RES;
            end
          end
        end
        S_WAIT_RES: begin
          // A result arriving on the timeout cycle still wins.
          if (ResultValid) begin
            rsp_data  <= DataResult;
            rsp_error <= 1'b0;
            Go        <= 1'b1;
            state     <= S_REL;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            rsp_data  <= '0;
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_REL: begin
          // Release is always a single high cycle; a second would read as an A load.
          if (ph_done) begin
            Go    <= 1'b0;
            state <= S_REL_LO;
          end
        end
        S_REL_LO: begin
          if (ph_done) begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_eval_driver.sv
// tb/tb_poly_eval_driver.sv - bench for poly_eval_driver with a behavioural serial evaluator
module tb_poly_eval_driver;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       req_valid, req_ready;
  logic [7:0] req_a, req_b, req_c, req_x;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_error;
  logic       Go;
  logic [7:0] DataIn;
  logic [7:0] DataResult;
  logic       ResultValid;

  int n_checks = 0;
  int n_fail   = 0;

  bit         ev_en    = 1'b1;
  int         ev_delay = 6;
  int         ev_phase = 0;
  int         ev_lo    = 0;
  logic       ev_go_d  = 1'b0;
  logic [7:0] ev_ops [4];

  poly_eval_driver #(
    .WIDTH(8), .GO_HIGH_CYCLES(2), .GO_LOW_CYCLES(2), .TIMEOUT(16)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_x(req_x),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_error(rsp_error),
    .Go(Go), .DataIn(DataIn),
    .DataResult(DataResult), .ResultValid(ResultValid)
  );

  always #5 Clock = ~Clock;

  // Evaluator: latches DataIn on each Go rise, raises ResultValid ev_delay low cycles
  // after the X load, and treats the next Go rise as the release.
  always @(negedge Clock) begin
    if (Reset) begin
      ev_phase = 0; ev_lo = 0; ev_go_d = 1'b0;
      ResultValid = 1'b0; DataResult = 8'd0;
    end else begin
      if (Go && !ev_go_d) begin
        if (ev_phase < 4) begin
          ev_ops[ev_phase] = DataIn;
          ev_phase++;
          ev_lo = 0;
        end else begin
          ResultValid = 1'b0;
          ev_phase = 0;
        end
      end else if (!Go && ev_phase == 4 && !ResultValid && ev_en) begin
        ev_lo++;
        if (ev_lo == ev_delay) begin
          DataResult  = ev_ops[0] * ev_ops[3] * ev_ops[3] + ev_ops[1] * ev_ops[3] + ev_ops[2];
          ResultValid = 1'b1;
        end
      end
      ev_go_d = Go;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_poly(input int a, input int b, input int c, input int x);
    return (a * x * x + b * x + c) % 256;
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  // Called at a negedge with the driver idle; returns at a negedge after the response handshake.
  task automatic do_req(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] x,
                        input int rdy_dly, input bit exp_err, input int exp_lat,
                        input bit pend, input logic [7:0] pa, input logic [7:0] pb,
                        input logic [7:0] pc, input logic [7:0] px);
    int   n, hi, rises, busy, exp_data;
    logic gp;
    req_a = a; req_b = b; req_c = c; req_x = x; req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    @(negedge Clock);
    if (pend) begin
      req_a = pa; req_b = pb; req_c = pc; req_x = px;
    end else begin
      req_valid = 1'b0;
    end
    n = 1; hi = 0; rises = 0; busy = 0; gp = 1'b0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      if (Go) hi++;
      if (Go && !gp) rises++;
      gp = Go;
      if (req_ready !== 1'b0) busy++;
      @(negedge Clock);
      n++;
    end
    exp_data = exp_err ? 0 : ref_poly(int'(a), int'(b), int'(c), int'(x));
    chk("rsp_latency", n, exp_lat);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_error", rsp_error, exp_err);
    chk("go_high_cycles", hi, exp_err ? 8 : 9);
    chk("go_rises", rises, exp_err ? 4 : 5);
    chk("req_ready_busy", busy, 0);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge Clock);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_data", rsp_data, exp_data);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge Clock);
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", rsp_valid, 0);
    chk("req_ready_after", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    logic [7:0] ra, rb, rc, rx;
    Reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = 8'd0; req_b = 8'd0; req_c = 8'd0; req_x = 8'd0;
    repeat (2) @(negedge Clock);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_error", rsp_error, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_go", Go, 0);
    chk("reset_datain", DataIn, 0);
    Reset = 1'b0;
    @(negedge Clock);

    do_req(8'd1, 8'd2, 8'd3, 8'd4, 0, 1'b0, 23, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    do_req(8'd5, 8'd0, 8'd0, 8'd10, 0, 1'b0, 23, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);

    // Back-to-back: second request is held on the port during the first transaction.
    do_req(8'd1, 8'd2, 8'd3, 8'd4, 0, 1'b0, 23, 1'b1, 8'd0, 8'd0, 8'd7, 8'd9);
    do_req(8'd0, 8'd0, 8'd7, 8'd9, 0, 1'b0, 23, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);

    do_req(8'd1, 8'd2, 8'd3, 8'd4, 10, 1'b0, 23, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);

    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
      rc = 8'($urandom_range(0, 255)); rx = 8'($urandom_range(0, 255));
      d = int'($urandom_range(3, 12));
      ev_delay = d;
      do_req(ra, rb, rc, rx, int'($urandom_range(0, 3)), 1'b0, 17 + d, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    end

    // Result arriving on the last timeout cycle still wins.
    ev_delay = 18;
    do_req(8'd3, 8'd1, 8'd4, 8'd1, 0, 1'b0, 35, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);

    // One cycle later it is a timeout; evaluator is left desynchronized.
    ev_delay = 19;
    do_req(8'd3, 8'd1, 8'd4, 8'd1, 0, 1'b1, 33, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    do_reset();

    ev_delay = 6;
    ev_en = 1'b0;
    do_req(8'd1, 8'd2, 8'd3, 8'd4, 2, 1'b1, 33, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    ev_en = 1'b1;
    do_reset();

    // Asynchronous reset during the B load high phase.
    req_a = 8'd1; req_b = 8'd2; req_c = 8'd3; req_x = 8'd4; req_valid = 1'b1;
    @(negedge Clock);
    req_valid = 1'b0;
    repeat (4) @(negedge Clock);
    chk("pre_reset_go", Go, 1);
    chk("pre_reset_datain", DataIn, 2);
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_go", Go, 0);
    chk("async_reset_datain", DataIn, 0);
    chk("async_reset_req_ready", req_ready, 1);
    chk("async_reset_rsp_valid", rsp_valid, 0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    do_req(8'd1, 8'd2, 8'd3, 8'd4, 0, 1'b0, 23, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_eval_driver.md
Name: poly_eval_driver

Overview:
- Initiator for the serial polynomial-evaluator interface (Go / DataIn / DataResult / ResultValid).
- Accepts one parallel request {a, b, c, x} on a valid/ready port and serializes it into four Go-handshaked operand loads.
- Waits for ResultValid, captures DataResult, issues the one-cycle release pulse, and returns the result on a valid/ready response port.
- Sits between a host/test sequencer and the evaluator; both blocks share Clock and Reset.

Parameters:
- WIDTH, 8, operand and result width.
- GO_HIGH_CYCLES, 2, cycles Go is held high per operand load; must be >=1.
- GO_LOW_CYCLES, 2, cycles Go is held low after each operand load; must be >=1.
- TIMEOUT, 16, maximum cycles to wait for ResultValid after the X load completes; must be >=8.

Ports:
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request.
- req_a, req_b, req_c, req_x  in  WIDTH each  operands; captured on the req_valid & req_ready cycle.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  (a*x*x + b*x + c) mod 2^WIDTH; 0 when rsp_error=1.
- rsp_error  out  1  ResultValid timeout occurred.
- Go  out  1  handshake strobe to the evaluator.
- DataIn  out  WIDTH  operand bus to the evaluator.
- DataResult  in  WIDTH  evaluator result.
- ResultValid  in  1  evaluator result-valid flag.

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_error=0; rsp_data=0; Go=0; DataIn=0; operand registers 0; all counters 0.
- IDLE:
  - req_ready=1.
  - On req_valid=1, register all four operands, load DataIn<=a, and go to LOAD_HI with op_idx=0.
  - req_ready=0 in every other state; requests arriving then are not lost, the requester holds them.
- LOAD_HI:
  - Go=1 for exactly GO_HIGH_CYCLES cycles.
  - DataIn holds the current operand for the whole state (the evaluator samples DataIn on the Go-rise edge).
  - Then go to LOAD_LO.
- LOAD_LO:
  - Go=0 for exactly GO_LOW_CYCLES cycles, still holding the current operand.
  - On exit, if op_idx<3: op_idx+1, DataIn<=next operand in order a, b, c, x, then back to LOAD_HI.
  - On exit with op_idx=3: go to WAIT_RES and clear the timeout counter.
- WAIT_RES:
  - Go=0.
  - If ResultValid=1, capture rsp_data<=DataResult, rsp_error<=0, and go to REL.
  - If the counter reaches TIMEOUT first, set rsp_data<=0, rsp_error<=1, and go to RESP without a release pulse. The evaluator is then desynchronized and only Reset recovers it.
  - Nominal latency: ResultValid rises on the 6th cycle after the first Go-low cycle of the X load.
- REL:
  - Go=1 for exactly one cycle, regardless of GO_HIGH_CYCLES. A second high cycle would be taken as an A load.
  - Then go to REL_LO.
- REL_LO: Go=0 for one cycle, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_error stay stable.
  - On rsp_ready=1, clear rsp_valid and go to IDLE. req_ready=1 on the following cycle; no same-cycle turnaround.
- Arithmetic: the driver performs none. rsp_data is DataResult verbatim, WIDTH bits, wrapping modulo 2^WIDTH.
- Timing: Go and DataIn are registered outputs, with no combinational path from any input.
- Reset mid-operation (any state): immediate return to reset values; any in-flight request and response is discarded.
- Timeout reached in the same cycle ResultValid=1: ResultValid wins, no error.

Decomposition:
- Shared package poly_eval_pkg holds:
  - state encoding localparams: S_IDLE, S_LOAD_HI, S_LOAD_LO, S_WAIT_RES, S_REL, S_REL_LO, S_RESP;
  - operand index constants: OP_A=0, OP_B=1, OP_C=2, OP_X=3.
- One sub-module, go_pulse_gen: a loadable down-counter that produces the Go high/low phase timing and a done strobe; reused for the LOAD and REL phases.
- The top level holds the FSM, operand mux and response registers.

Test Plan:
- Driver paired with the evaluator, a=1 b=2 c=3 x=4, rsp_ready=1 -> rsp_valid with rsp_data=27, rsp_error=0; Go shows four 2-high/2-low pulses, then one 1-cycle release pulse.
- a=5 b=0 c=0 x=10 -> rsp_data=244 (500 mod 256).
- Two back-to-back requests (1,2,3,4) then (0,0,7,9) -> 27 then 7; the second request is accepted only after the first response handshakes; the evaluator completes the second pass correctly.
- rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_valid, rsp_data=27 and req_ready=0 stay stable; the response completes on the first rsp_ready=1.
- ResultValid tied 0 (stub evaluator) -> rsp_valid with rsp_error=1 and rsp_data=0 exactly TIMEOUT cycles after WAIT_RES entry; no release pulse on Go.
- Reset asserted during the second LOAD_HI -> Go=0, DataIn=0, req_ready=1 and rsp_valid=0 asynchronously; a fresh request (1,2,3,4) after reset returns 27.
